lsu_bus_bridge: RTL and testbench
=================================

# lsu_bus_bridge

Load/store bridge sitting directly downstream of the single-cycle RISC-V core's data-memory port. It turns the core's one-cycle load/store request into a valid/ready bus transaction with byte strobes, sign/zero-extends load data, and holds the core in stall until the bus completes. It also flags misaligned or illegal-size accesses without issuing them.

## Interface
- No parameters; all widths fixed at 32-bit data/address.
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-low reset
- core_req  input  1  current instruction is a load or store
- core_we  input  1  1 = store, 0 = load
- core_addr  input  32  byte address (core ALU output)
- core_wdata  input  32  store data (rs2)
- core_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_rdata  output  32  extended load data, valid in DONE
- core_stall  output  1  freeze core PC/register write
- err_misaligned  output  1  access rejected (misaligned or illegal funct3)
- bus_valid  output  1  request valid
- bus_ready  input  1  request accepted
- bus_we  output  1  write request
- bus_addr  output  32  word address, {core_addr[31:2], 2'b00}
- bus_wstrb  output  4  byte-lane strobes (0000 on reads)
- bus_wdata  output  32  lane-replicated store data
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read data word

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE: core_req=1 and access legal -> REQ, core_stall=1 the same cycle (combinational). Illegal -> err_misaligned=1 combinationally, core_stall=0, stay IDLE, no bus activity. core_req=0 -> stay.
- Legality: funct3 000/100 any offset; 001/101 offset 0 or 2; 010 offset 0; funct3 011/110/111 always illegal; stores with funct3 1xx illegal.
- REQ: bus_valid=1, stall=1; bus_addr/we/wstrb/wdata driven from registered copies captured on IDLE->REQ edge. On bus_ready: store -> DONE, load -> WAIT_R.
- WAIT_R: stall=1; on bus_rvalid capture extended bus_rdata into core_rdata register -> DONE.
- DONE: stall=0, core_rdata held; core retires at this edge; -> IDLE unconditionally.
- Store lanes (off=addr[1:0]): SB wstrb=4'b0001<<off, wdata={4{byte}}; SH wstrb=0011 (off 0) or 1100 (off 2), wdata={2{half}}; SW wstrb=1111.
- Load extension: select byte at off*8 or half at off[1]*16; B/H sign-extend bit 7/15; BU/HU zero-extend; W pass-through.
- Core inputs are sampled only on IDLE->REQ; changes during stall ignored.
- bus_rvalid outside WAIT_R ignored. bus_ready outside REQ ignored.

## Timing
- Reset (async, rst=0): state IDLE; bus_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, core_rdata=0. core_stall and err_misaligned follow IDLE combinational rules (0 when core_req=0).
- Reset asserted mid-transaction: bus_valid drops immediately, pending response discarded.
- bus_valid, once high, stays high with stable payload until the bus_ready cycle (inclusive).
- Minimum latency, store with bus_ready already high: IDLE(stall) -> REQ -> DONE = 3 cycles, stall high 2.
- Minimum load, ready and rvalid each one cycle after prior state entered: IDLE -> REQ -> WAIT_R -> DONE = 4 cycles.
- rvalid in the same cycle as bus_ready is not accepted; earliest rvalid is first WAIT_R cycle.
- Back-to-back accesses: DONE -> IDLE -> REQ; one idle cycle between bus requests.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, bus_ready tied 1 -> one bus_valid cycle, addr 0x100, wstrb 1111, stall high exactly 2 cycles.
- SB addr 0x103, wdata 0x000000A5 -> bus_addr 0x100, wstrb 1000, wdata 0xA5A5A5A5.
- LB addr 0x202, bus_rdata 0x0080FF00 with rvalid after 3 wait cycles -> core_rdata 0xFFFFFF80 in DONE; LBU same -> 0x00000080; LH addr 0x202 -> 0x00000080.
- LW addr 0x301 and SH addr 0x301 -> err_misaligned=1, stall=0, bus_valid never asserted.
- bus_ready held low 5 cycles in REQ while core_addr toggles -> bus_valid/addr/wdata stable all 6 cycles, then completes with originally captured values.
- rst pulled low during WAIT_R, later stray rvalid -> bus_valid 0 immediately, state IDLE, core_rdata 0, stray rvalid ignored.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core data port and a valid/ready bus.
// Stalls the core for the whole transaction and rejects illegal or misaligned accesses without issuing them.
module lsu_bus_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        err_misaligned,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;

    logic        legal;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Unsigned sizes exist only for loads, so stores with funct3[2] set are rejected.
    always_comb begin
        legal = 1'b0;
        case (core_funct3)
            3'b000:  legal = 1'b1;
            3'b100:  legal = !core_we;
            3'b001:  legal = !core_addr[0];
            3'b101:  legal = !core_we && !core_addr[0];
            3'b010:  legal = (core_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        st_strb = 4'b1111;
        st_data = core_wdata;
        case (core_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << core_addr[1:0];
                st_data = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                st_strb = core_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{core_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!core_we) begin
            st_strb = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = bus_rdata[7:0];
        case (off_q)
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            2'd3:    ld_byte = bus_rdata[31:24];
            default: ;
        endcase
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wstrb_d        = wstrb_q;
        wdata_d        = wdata_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        rdata_d        = rdata_q;
        core_stall     = 1'b0;
        err_misaligned = 1'b0;
        bus_valid      = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    if (legal) begin
                        core_stall = 1'b1;
                        state_d    = REQ;
                        we_d       = core_we;
                        addr_d     = {core_addr[31:2], 2'b00};
                        wstrb_d    = st_strb;
                        wdata_d    = st_data;
                        funct3_d   = core_funct3;
                        off_d      = core_addr[1:0];
                    end else begin
                        err_misaligned = 1'b1;
                    end
                end
            end
            REQ: begin
                bus_valid  = 1'b1;
                core_stall = 1'b1;
                if (bus_ready) begin
                    state_d = we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                core_stall = 1'b1;
                if (bus_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'h0;
            off_q    <= 2'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wstrb  = wstrb_q;
    assign bus_wdata  = wdata_q;
    assign core_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: expected bus payloads and load results are queued at issue
// and popped when the bridge presents the request or finishes the access.
module tb_lsu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_stall, err_misaligned;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    lsu_bus_bridge dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall), .err_misaligned(err_misaligned),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t model_txn(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.addr  = a & 32'hFFFF_FFFC;
        t.we    = we;
        t.strb  = 4'h0;
        t.wdata = d;
        if (we) begin
            case (f3)
                3'b000: begin t.strb = 4'b0001 << a[1:0]; t.wdata = {24'h0, d[7:0]} * 32'h0101_0101; end
                3'b001: begin t.strb = a[1] ? 4'hC : 4'h3; t.wdata = {16'h0, d[15:0]} * 32'h0001_0001; end
                default: t.strb = 4'hF;
            endcase
        end
        return t;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // One full legal access: ready after rdy_wait low REQ cycles, rvalid after rv_wait idle WAIT_R cycles.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input int rdy_wait,
                          input int rv_wait, input logic [31:0] rword, input logic toggle);
        txn_t t;
        int   k = 0, w = 0, n_stall = 0, n_valid = 0;
        logic hs = 1'b0, fin = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = d;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h5A5A_0F0F;
        exp_q.push_back(model_txn(we, f3, a, d));
        if (!we) rd_q.push_back(model_load(f3, a, rword));
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) chk({tag, " err_idle"}, {31'h0, err_misaligned}, 32'h0);
            if (!core_stall) begin fin = 1'b1; break; end
            n_stall++;
            if (bus_valid) begin
                n_valid++;
                k++;
                bus_ready = (k > rdy_wait);
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected_req"}, 32'h1, 32'h0);
                end else begin
                    t = exp_q[0];
                    chk({tag, " addr"}, bus_addr, t.addr);
                    chk({tag, " we"}, {31'h0, bus_we}, {31'h0, t.we});
                    chk({tag, " wstrb"}, {28'h0, bus_wstrb}, {28'h0, t.strb});
                    if (we) chk({tag, " wdata"}, bus_wdata, t.wdata);
                    if (bus_ready) begin hs = 1'b1; void'(exp_q.pop_front()); end
                end
                if (toggle) begin core_addr = ~core_addr; core_wdata = ~core_wdata; end
            end else begin
                bus_ready = 1'b0;
                if (hs && !we) begin
                    w++;
                    bus_rvalid = (w > rv_wait);
                    bus_rdata  = bus_rvalid ? rword : 32'h5A5A_0F0F;
                end
            end
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        chk({tag, " finished"}, {31'h0, fin}, 32'h1);
        chk({tag, " stall_cycles"}, n_stall, 1 + rdy_wait + 1 + (we ? 0 : rv_wait + 1));
        chk({tag, " valid_cycles"}, n_valid, rdy_wait + 1);
        if (!we && rd_q.size() != 0) chk({tag, " rdata"}, core_rdata, rd_q.pop_front());
    endtask

    task automatic illegal(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = 32'h1111_2222;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk({tag, " err"}, {31'h0, err_misaligned}, 32'h1);
            chk({tag, " stall"}, {31'h0, core_stall}, 32'h0);
            chk({tag, " valid"}, {31'h0, bus_valid}, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        core_funct3 = 3'b010; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #12;
        chk("rst valid", {31'h0, bus_valid}, 32'h0);
        chk("rst we", {31'h0, bus_we}, 32'h0);
        chk("rst wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("rst addr", bus_addr, 32'h0);
        chk("rst wdata", bus_wdata, 32'h0);
        chk("rst rdata", core_rdata, 32'h0);
        chk("rst stall", {31'h0, core_stall}, 32'h0);
        chk("rst err", {31'h0, err_misaligned}, 32'h0);
        #11 rst = 1'b1;

        access("SW",  1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        access("SB",  1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
        access("SH",  1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 1, 0, 32'h0, 1'b0);
        access("LB",  1'b0, 3'b000, 32'h202, 32'h0,         0, 3, 32'h0080_FF00, 1'b0);
        access("LBU", 1'b0, 3'b100, 32'h202, 32'h0,         0, 3, 32'h0080_FF00, 1'b0);
        access("LH",  1'b0, 3'b001, 32'h202, 32'h0,         0, 3, 32'h0080_FF00, 1'b0);
        access("LH0", 1'b0, 3'b001, 32'h200, 32'h0,         2, 1, 32'h0080_FF00, 1'b0);
        access("LHU", 1'b0, 3'b101, 32'h200, 32'h0,         0, 0, 32'h0080_FF00, 1'b0);
        access("LB1", 1'b0, 3'b000, 32'h201, 32'h0,         0, 0, 32'h0080_FF00, 1'b0);

        illegal("LW misal", 1'b0, 3'b010, 32'h301);
        illegal("SH misal", 1'b1, 3'b001, 32'h301);
        illegal("SBU",      1'b1, 3'b100, 32'h300);
        illegal("F3 011",   1'b0, 3'b011, 32'h300);

        access("SW hold", 1'b1, 3'b010, 32'h400, 32'h0BAD_F00D, 5, 0, 32'h0, 1'b1);
        access("LW",      1'b0, 3'b010, 32'h300, 32'h0,         0, 0, 32'hCAFE_F00D, 1'b0);

        // Reset while a request is on the bus.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h500;
        @(posedge clk); #2;
        chk("rstREQ valid_before", {31'h0, bus_valid}, 32'h1);
        rst = 1'b0; core_req = 1'b0;
        #1;
        chk("rstREQ valid", {31'h0, bus_valid}, 32'h0);
        chk("rstREQ stall", {31'h0, core_stall}, 32'h0);
        chk("rstREQ addr", bus_addr, 32'h0);
        @(negedge clk) rst = 1'b1;

        access("LW2", 1'b0, 3'b010, 32'h304, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0);

        // Reset while waiting for read data; a later stray rvalid must be ignored.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b000; core_addr = 32'h204;
        @(negedge clk) bus_ready = 1'b1;
        @(negedge clk) bus_ready = 1'b0;
        chk("rstWR stall_before", {31'h0, core_stall}, 32'h1);
        #2 rst = 1'b0; core_req = 1'b0;
        #1;
        chk("rstWR valid", {31'h0, bus_valid}, 32'h0);
        chk("rstWR rdata", core_rdata, 32'h0);
        chk("rstWR stall", {31'h0, core_stall}, 32'h0);
        @(negedge clk) rst = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("stray rdata", core_rdata, 32'h0);
        chk("stray stall", {31'h0, core_stall}, 32'h0);
        chk("stray valid", {31'h0, bus_valid}, 32'h0);
        bus_rvalid = 1'b0;

        access("SW post", 1'b1, 3'b010, 32'h600, 32'h89AB_CDEF, 0, 0, 32'h0, 1'b0);
        chk("queue empty", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
